// File: rtl/rgmii_rx_decode.sv
// RGMII receive decoder: turns DDR-captured nibbles into GMII-style bytes, tracks
// in-band link status and counts good/errored frames.
module rgmii_rx_decode #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           rxd_q1,
  input  logic [3:0]           rxd_q2,
  input  logic                 rxctl_q1,
  input  logic                 rxctl_q2,
  input  logic                 mii_mode,
  output logic [7:0]           gmii_rxd,
  output logic                 gmii_rx_dv,
  output logic                 gmii_rx_er,
  output logic                 gmii_rx_ce,
  output logic                 odd_nibble,
  output logic                 link_up,
  output logic [1:0]           link_speed,
  output logic                 link_duplex,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  state_t     state_q, state_n;
  logic       dv_p0, er_p0, mode_p0, stat_smp_p0, frame_end_p0, frame_bad_p0;
  logic       armed_q, in_frame_q, frame_err_q, mode_q, tog_q, lo_er_q, stat_vld_q;
  logic [3:0] lo_nib_q, stat_q;
  logic [7:0] rxd_n;
  logic       rx_dv_n, rx_er_n, ce_n, odd_n, tog_n, lo_er_n, frame_err_n;
  logic [3:0] lo_nib_n;

  // A frame still in progress when reset releases is ignored until dv has been low once.
  assign dv_p0        = rxctl_q1 & armed_q;
  assign er_p0        = rxctl_q1 ^ rxctl_q2;
  assign mode_p0      = in_frame_q ? mode_q : mii_mode;
  assign stat_smp_p0  = ~rxctl_q1 & ~er_p0 & (rxd_q1 == rxd_q2);
  assign frame_end_p0 = in_frame_q & ~dv_p0;
  assign frame_bad_p0 = frame_err_q | odd_n;
  assign frame_err_n  = dv_p0 & ((in_frame_q & frame_err_q) | er_p0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_n;
  end

  always_comb begin
    state_n  = state_q;
    rxd_n    = 8'h00;
    rx_dv_n  = 1'b0;
    rx_er_n  = 1'b0;
    ce_n     = 1'b0;
    odd_n    = 1'b0;
    tog_n    = 1'b0;
    lo_nib_n = lo_nib_q;
    lo_er_n  = lo_er_q;
    if (!mode_p0) begin
      rxd_n   = {rxd_q2, rxd_q1};
      rx_dv_n = dv_p0;
      rx_er_n = er_p0;
      ce_n    = 1'b1;
      state_n = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (dv_p0) begin
            lo_nib_n = rxd_q1;
            lo_er_n  = er_p0;
            state_n  = HIGH;
          end else begin
            ce_n  = tog_q;
            tog_n = ~tog_q;
          end
        end
        HIGH: begin
          if (dv_p0) begin
            rxd_n   = {rxd_q1, lo_nib_q};
            rx_dv_n = 1'b1;
            rx_er_n = lo_er_q | er_p0;
            ce_n    = 1'b1;
            state_n = LOW;
          end else begin
            odd_n    = 1'b1;
            lo_nib_n = 4'h0;
            lo_er_n  = 1'b0;
            tog_n    = 1'b1;
            state_n  = IDLE;
          end
        end
        LOW: begin
          if (dv_p0) begin
            lo_nib_n = rxd_q1;
            lo_er_n  = er_p0;
            state_n  = HIGH;
          end else begin
            tog_n   = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // p0 -> p1: registered outputs, frame accounting and status history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q     <= 1'b0;
      in_frame_q  <= 1'b0;
      frame_err_q <= 1'b0;
      mode_q      <= 1'b0;
      tog_q       <= 1'b0;
      lo_nib_q    <= 4'h0;
      lo_er_q     <= 1'b0;
      stat_q      <= 4'h0;
      stat_vld_q  <= 1'b0;
      gmii_rxd    <= 8'h00;
      gmii_rx_dv  <= 1'b0;
      gmii_rx_er  <= 1'b0;
      gmii_rx_ce  <= 1'b0;
      odd_nibble  <= 1'b0;
      link_up     <= 1'b0;
      link_speed  <= 2'b00;
      link_duplex <= 1'b0;
      frame_cnt   <= '0;
      err_cnt     <= '0;
    end else begin
      armed_q     <= armed_q | ~rxctl_q1;
      in_frame_q  <= dv_p0;
      frame_err_q <= frame_err_n;
      mode_q      <= mode_p0;
      tog_q       <= tog_n;
      lo_nib_q    <= lo_nib_n;
      lo_er_q     <= lo_er_n;
      gmii_rxd    <= rxd_n;
      gmii_rx_dv  <= rx_dv_n;
      gmii_rx_er  <= rx_er_n;
      gmii_rx_ce  <= ce_n;
      odd_nibble  <= odd_n;
      if (frame_end_p0) begin
        if (frame_bad_p0) err_cnt   <= sat_inc(err_cnt);
        else              frame_cnt <= sat_inc(frame_cnt);
      end
      // Status is accepted only when the same value is seen on two samples in a row.
      if (rxctl_q1) begin
        stat_vld_q <= 1'b0;
      end else if (stat_smp_p0) begin
        stat_q     <= rxd_q1;
        stat_vld_q <= 1'b1;
        if (stat_vld_q && (stat_q == rxd_q1)) begin
          link_up     <= rxd_q1[0];
          link_speed  <= rxd_q1[2:1];
          link_duplex <= rxd_q1[3];
        end
      end
    end
  end

endmodule

// File: tb/tb_rgmii_rx_decode.sv
// Bench for rgmii_rx_decode: table of cycle vectors checked through a scoreboard,
// plus hand-written sequences for idle strobe, link status and reset.
`timescale 1ns/1ps
module tb_rgmii_rx_decode;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    rxd_q1, rxd_q2;
  logic          rxctl_q1, rxctl_q2, mii_mode;
  logic [7:0]    gmii_rxd;
  logic          gmii_rx_dv, gmii_rx_er, gmii_rx_ce, odd_nibble;
  logic          link_up, link_duplex;
  logic [1:0]    link_speed;
  logic [CW-1:0] frame_cnt, err_cnt;

  rgmii_rx_decode #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .rxd_q1(rxd_q1), .rxd_q2(rxd_q2),
    .rxctl_q1(rxctl_q1), .rxctl_q2(rxctl_q2), .mii_mode(mii_mode),
    .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
    .gmii_rx_ce(gmii_rx_ce), .odd_nibble(odd_nibble), .link_up(link_up),
    .link_speed(link_speed), .link_duplex(link_duplex),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         nm;
    logic          md;
    logic [3:0]    q1, q2;
    logic          c1, c2;
    logic [7:0]    rxd;
    logic          dv, er, ce, odd, ce_care;
    logic          chk_cnt;
    logic [CW-1:0] fc, ec;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  vec_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(string nm, logic md, logic [3:0] q1, logic [3:0] q2,
                              logic c1, logic c2, logic [7:0] rxd, logic dv, logic er,
                              logic ce, logic odd, logic care);
    vec_t v;
    v.nm = nm; v.md = md; v.q1 = q1; v.q2 = q2; v.c1 = c1; v.c2 = c2;
    v.rxd = rxd; v.dv = dv; v.er = er; v.ce = ce; v.odd = odd; v.ce_care = care;
    v.chk_cnt = 1'b0; v.fc = '0; v.ec = '0;
    return v;
  endfunction

  function automatic vec_t idle1k();
    return mk("idle1k", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
  endfunction

  function automatic vec_t byte1k(string nm, logic [7:0] b, logic err);
    return mk(nm, 1'b0, b[3:0], b[7:4], 1'b1, ~err, b, 1'b1, err, 1'b1, 1'b0, 1'b1);
  endfunction

  function automatic vec_t idle10(logic odd);
    return mk("idle10", 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, odd, 1'b0);
  endfunction

  // A nibble in 10/100 mode; when has_b is set the completed byte b is expected next cycle.
  function automatic vec_t nib(string nm, logic [3:0] q, logic err, logic has_b,
                               logic [7:0] b, logic er_exp);
    return mk(nm, 1'b1, q, 4'h0, 1'b1, ~err, b, has_b, er_exp, has_b, 1'b0, 1'b1);
  endfunction

  function automatic vec_t cnt_chk(vec_t v, logic [CW-1:0] fc, logic [CW-1:0] ec);
    vec_t r;
    r = v; r.chk_cnt = 1'b1; r.fc = fc; r.ec = ec;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic md, input logic [3:0] q1, input logic [3:0] q2,
                       input logic c1, input logic c2);
    @(negedge clk);
    mii_mode = md; rxd_q1 = q1; rxd_q2 = q2; rxctl_q1 = c1; rxctl_q2 = c2;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && sb.size() != 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: each scoreboard entry matches the outputs one clock after it was driven.
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      n_vec++;
      if ((mon_e.ce_care && gmii_rx_ce !== mon_e.ce) || odd_nibble !== mon_e.odd ||
          (mon_e.ce && (gmii_rx_dv !== mon_e.dv || gmii_rx_er !== mon_e.er)) ||
          (mon_e.ce && mon_e.dv && gmii_rxd !== mon_e.rxd)) begin
        n_bad++;
        $display("FAIL vec %s: got rxd=%h dv=%b er=%b ce=%b odd=%b expected rxd=%h dv=%b er=%b ce=%b odd=%b",
                 mon_e.nm, gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_rx_ce, odd_nibble,
                 mon_e.rxd, mon_e.dv, mon_e.er, mon_e.ce, mon_e.odd);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ce_s;
    logic       alt;

    // 1000 mode: preamble frame, errored frame, one-cycle frame
    tbl.push_back(idle1k()); tbl.push_back(idle1k());
    tbl.push_back(byte1k("b55a", 8'h55, 1'b0)); tbl.push_back(byte1k("b55b", 8'h55, 1'b0));
    tbl.push_back(byte1k("bD5", 8'hD5, 1'b0));  tbl.push_back(byte1k("bAB", 8'hAB, 1'b0));
    tbl.push_back(idle1k()); tbl.push_back(cnt_chk(idle1k(), 4'd1, 4'd0));
    tbl.push_back(byte1k("e55", 8'h55, 1'b0));  tbl.push_back(byte1k("e12", 8'h12, 1'b1));
    tbl.push_back(byte1k("e34", 8'h34, 1'b0));
    tbl.push_back(idle1k()); tbl.push_back(cnt_chk(idle1k(), 4'd1, 4'd1));
    tbl.push_back(byte1k("one7E", 8'h7E, 1'b0));
    tbl.push_back(idle1k()); tbl.push_back(cnt_chk(idle1k(), 4'd2, 4'd1));
    // 10/100 mode: even frame, odd frame, error on the low nibble
    tbl.push_back(idle10(1'b0)); tbl.push_back(idle10(1'b0)); tbl.push_back(idle10(1'b0));
    tbl.push_back(nib("n5", 4'h5, 1'b0, 1'b0, 8'h00, 1'b0));
    tbl.push_back(nib("nA", 4'hA, 1'b0, 1'b1, 8'hA5, 1'b0));
    tbl.push_back(nib("n3", 4'h3, 1'b0, 1'b0, 8'h00, 1'b0));
    tbl.push_back(nib("nC", 4'hC, 1'b0, 1'b1, 8'hC3, 1'b0));
    tbl.push_back(idle10(1'b0)); tbl.push_back(cnt_chk(idle10(1'b0), 4'd3, 4'd1));
    tbl.push_back(nib("o1", 4'h1, 1'b0, 1'b0, 8'h00, 1'b0));
    tbl.push_back(nib("o2", 4'h2, 1'b0, 1'b1, 8'h21, 1'b0));
    tbl.push_back(nib("o3", 4'h3, 1'b0, 1'b0, 8'h00, 1'b0));
    tbl.push_back(idle10(1'b1)); tbl.push_back(cnt_chk(idle10(1'b0), 4'd3, 4'd2));
    tbl.push_back(nib("r6", 4'h6, 1'b1, 1'b0, 8'h00, 1'b0));
    tbl.push_back(nib("r9", 4'h9, 1'b0, 1'b1, 8'h96, 1'b1));
    tbl.push_back(idle10(1'b0)); tbl.push_back(cnt_chk(idle10(1'b0), 4'd3, 4'd3));
    // Mode request flips to 10/100 mid-frame; bytes stay in 1000 format until dv falls
    tbl.push_back(idle1k()); tbl.push_back(idle1k());
    tbl.push_back(byte1k("m11", 8'h11, 1'b0));
    tbl.push_back(mk("m22", 1'b1, 4'h2, 4'h2, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk("m33", 1'b1, 4'h3, 4'h3, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
    tbl.push_back(idle1k()); tbl.push_back(cnt_chk(idle1k(), 4'd4, 4'd3));
    // Counter saturation
    for (int i = 5; i <= 16; i++) begin
      tbl.push_back(byte1k("sg", 8'h7E, 1'b0));
      tbl.push_back((i >= 15) ? cnt_chk(idle1k(), 4'd15, 4'd3) : idle1k());
    end
    for (int i = 4; i <= 16; i++) begin
      tbl.push_back(byte1k("se", 8'h7E, 1'b1));
      tbl.push_back((i >= 15) ? cnt_chk(idle1k(), 4'd15, 4'd15) : idle1k());
    end

    rst_n = 1'b0; mii_mode = 1'b0;
    rxd_q1 = 4'h0; rxd_q2 = 4'h0; rxctl_q1 = 1'b0; rxctl_q2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_rx_ce, odd_nibble,
                          link_up, link_speed, link_duplex, frame_cnt, err_cnt}, 32'h0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].md, tbl[i].q1, tbl[i].q2, tbl[i].c1, tbl[i].c2);
      sb.push_back(tbl[i]);
      if (tbl[i].chk_cnt) begin
        drain();
        chk($sformatf("counters@%0d", i), {frame_cnt, err_cnt}, {tbl[i].fc, tbl[i].ec});
      end
    end
    drain();

    // 10/100 idle: byte strobe alternates
    drive(1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ce_s[i] = gmii_rx_ce;
    end
    alt = (ce_s[0] ^ ce_s[1]) & (ce_s[1] ^ ce_s[2]) & (ce_s[2] ^ ce_s[3]);
    chk("ce_alternate_10_100", {31'd0, alt}, 32'd1);

    // In-band status: {duplex, speed, link} compared as 4 bits
    drive(1'b1, 4'hD, 4'hD, 1'b0, 1'b0);
    drive(1'b1, 4'hD, 4'hD, 1'b0, 1'b0);
    chk("status_one_sample", {28'd0, link_duplex, link_speed, link_up}, 32'h0);
    drive(1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("status_two_samples", {28'd0, link_duplex, link_speed, link_up}, 32'hD);
    drive(1'b1, 4'hD, 4'hD, 1'b0, 1'b0);
    drive(1'b1, 4'h0, 4'h0, 1'b0, 1'b1);
    chk("status_glitch", {28'd0, link_duplex, link_speed, link_up}, 32'hD);
    drive(1'b1, 4'hD, 4'hD, 1'b0, 1'b0);
    drive(1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("status_er_ignored", {28'd0, link_duplex, link_speed, link_up}, 32'hD);
    drive(1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("status_one_zero", {28'd0, link_duplex, link_speed, link_up}, 32'hD);
    drive(1'b1, 4'hD, 4'hD, 1'b0, 1'b0);
    chk("status_link_down", {28'd0, link_duplex, link_speed, link_up}, 32'h0);
    drive(1'b1, 4'hD, 4'hD, 1'b0, 1'b0);
    drive(1'b0, 4'h0, 4'h1, 1'b0, 1'b0);
    chk("status_relink", {28'd0, link_duplex, link_speed, link_up}, 32'hD);

    // Reset in the middle of a 1000 frame aborts it uncounted
    drive(1'b0, 4'h0, 4'h1, 1'b0, 1'b0);
    drive(1'b0, 4'h5, 4'h5, 1'b1, 1'b1);
    drive(1'b0, 4'h5, 4'h5, 1'b1, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midframe_reset_outputs", {gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_rx_ce, odd_nibble,
                                   link_up, link_speed, link_duplex, frame_cnt, err_cnt}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    drive(1'b0, 4'h0, 4'h1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("aborted_frame_uncounted", {24'd0, frame_cnt, err_cnt}, 32'h00);
    drive(1'b0, 4'h5, 4'hD, 1'b1, 1'b1);
    drive(1'b0, 4'h0, 4'h1, 1'b0, 1'b0);
    @(negedge clk);
    chk("frame_after_reset", {24'd0, frame_cnt, err_cnt}, 32'h10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rgmii_rx_decode.md
RGMII_RX_DECODE -- requirements
Module: rgmii_rx_decode

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, width of the frame and error counters.
REQ-002 SHALL have port clk  input  1  RX clock, the same clock that drives the input DDR registers; single clock domain.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rxd_q1  input  4  rising-edge RGMII data nibble from the input DDR register.
REQ-005 SHALL have port rxd_q2  input  4  falling-edge RGMII data nibble from the input DDR register.
REQ-006 SHALL have port rxctl_q1  input  1  rising-edge RX_CTL, meaning RX_DV.
REQ-007 SHALL have port rxctl_q2  input  1  falling-edge RX_CTL, meaning RX_DV xor RX_ER.
REQ-008 SHALL have port mii_mode  input  1  1 = 10/100 nibble mode, 0 = 1000 byte mode.
REQ-009 SHALL have port gmii_rxd  output  8  assembled receive byte.
REQ-010 SHALL have port gmii_rx_dv  output  1  data valid, qualified by gmii_rx_ce.
REQ-011 SHALL have port gmii_rx_er  output  1  receive error, qualified by gmii_rx_ce.
REQ-012 SHALL have port gmii_rx_ce  output  1  byte strobe.
REQ-013 SHALL have port odd_nibble  output  1  one-cycle pulse when a 10/100 frame ends on a half byte.
REQ-014 SHALL have port link_up  output  1  in-band link status.
REQ-015 SHALL have port link_speed  output  2  in-band speed: 00 = 10M, 01 = 100M, 10 = 1000M.
REQ-016 SHALL have port link_duplex  output  1  in-band duplex, 1 = full duplex.
REQ-017 SHALL have port frame_cnt  output  CNT_WIDTH  count of good frames.
REQ-018 SHALL have port err_cnt  output  CNT_WIDTH  count of errored frames.

Function
REQ-019 SHALL decode dv = rxctl_q1 and er = rxctl_q1 ^ rxctl_q2 in every cycle.
REQ-020 SHALL register all outputs.
REQ-021 SHALL, in 1000 mode, output gmii_rxd = {rxd_q2, rxd_q1} with gmii_rx_dv = dv, gmii_rx_er = er and gmii_rx_ce = 1, one cycle after the inputs are sampled.
REQ-022 SHALL run a 10/100 assembly FSM with states IDLE, LOW and HIGH; only rxd_q1 is used in 10/100 mode.
REQ-023 SHALL, in IDLE with dv = 1, store the nibble as the low half of the byte and go to HIGH.
REQ-024 SHALL, in HIGH with dv = 1, output {rxd_q1, stored low nibble} with gmii_rx_ce = 1 one cycle later and go to LOW.
REQ-025 SHALL, in LOW with dv = 1, store the next low nibble and go to HIGH.
REQ-026 SHALL OR er across both nibbles of a byte into gmii_rx_er.
REQ-027 SHALL keep gmii_rx_ce = 0 in 10/100 mode except on byte output cycles.
REQ-028 SHALL, when dv = 0 in HIGH, discard the stored nibble, pulse odd_nibble for 1 cycle and go to IDLE.
REQ-029 SHALL, when dv = 0 in LOW, go to IDLE with no pulse.
REQ-030 SHALL, in 10/100 mode with dv = 0, output gmii_rx_ce = 1 once per two clocks with gmii_rx_dv = 0.
REQ-031 SHALL latch the effective mode from mii_mode only while the frame is idle (dv = 0); a mode change mid-frame SHALL take effect after dv falls.
REQ-032 SHALL treat a cycle with dv = 0, er = 0 and rxd_q1 == rxd_q2 as an in-band status sample, with bit0 = link, bits[2:1] = speed, bit3 = duplex.
REQ-033 SHALL update link_up, link_speed and link_duplex only after two consecutive identical status samples.
REQ-034 SHALL ignore a status sample where dv = 0 and er = 1 (carrier extend or false carrier).
REQ-035 SHALL define a frame as an interval with dv = 1; a frame is errored if er = 1 in any cycle while dv = 1.
REQ-036 SHALL, on the cycle after dv falls, increment exactly one of frame_cnt (good frame) or err_cnt (errored frame).
REQ-037 SHALL count an odd-nibble frame as errored.
REQ-038 SHALL saturate both counters at all-ones with no wrap-around.
REQ-039 SHALL give a frame of exactly 1 cycle normal end-of-frame handling.

Reset
REQ-040 SHALL, while rst_n = 0, drive all outputs to 0, including both counters and link_speed = 00.
REQ-041 SHALL, while rst_n = 0, hold the FSM in IDLE, clear the stored nibble and status history, and latch the effective mode from mii_mode.
REQ-042 SHALL, on reset asserted mid-frame, abort the frame without counting it; after release, the next dv rise starts a new frame.

Verification
REQ-043 SHALL cover 1000 mode: frame of bytes 55 55 D5 AB with dv = 1 on each -> those bytes on gmii_rxd with 1-cycle latency, gmii_rx_ce constant 1, frame_cnt = 1.
REQ-044 SHALL cover 10/100 mode: nibbles 5, A, 3, C -> bytes A5 then C3 with gmii_rx_ce pulsing every 2nd cycle, frame_cnt = 1.
REQ-045 SHALL cover 10/100 mode with 3 nibbles -> one byte output, odd_nibble pulse of 1 cycle, err_cnt = 1, frame_cnt unchanged.
REQ-046 SHALL cover 1000 mode with one cycle of rxctl_q1 = 1, rxctl_q2 = 0 mid-frame -> gmii_rx_er = 1 on that byte, err_cnt = 1.
REQ-047 SHALL cover idle nibbles D, D on two consecutive cycles -> link_up = 1, link_speed = 10, link_duplex = 1; a single-cycle glitch -> status unchanged.
REQ-048 SHALL cover forcing frame_cnt to all-ones and sending one good frame -> frame_cnt stays all-ones.
